// File: rtl/switch_reader.sv
// Board switch input port: synchronises and debounces 24 switches, keeps sticky
// per-switch change flags and serves both through a chip-selected 16-bit read port.
module switch_reader #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned STABLE_N = 3
) (
    input  logic        switch_clk,
    input  logic        ledrst,
    input  logic        switchcs,
    input  logic        switchread,
    input  logic [1:0]  switchaddr,
    input  logic [23:0] switch_i,
    output logic [15:0] switchrdata
);

    localparam int unsigned NBITS  = 24;
    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FILL_W = $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(STABLE_N - 1);

    logic [NBITS-1:0]                 sync1_q, sync1_d;
    logic [NBITS-1:0]                 sync2_q, sync2_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NBITS-1:0][STABLE_N-1:0]   hist_q, hist_d;
    logic [NBITS-1:0]                 deb_q, deb_d;
    logic [NBITS-1:0]                 flag_q, flag_d;
    logic [FILL_W-1:0]                fill_q, fill_d;
    logic                             primed_q, primed_d;
    logic [15:0]                      rdata_q, rdata_d;

    logic                             tick;
    logic                             rd_en;
    logic [NBITS-1:0][STABLE_N-1:0]   hist_nxt;
    logic [NBITS-1:0]                 agree1;
    logic [NBITS-1:0]                 agree0;
    logic [NBITS-1:0]                 set_mask;
    logic [NBITS-1:0]                 clr_mask;

    always_comb begin
        sync1_d  = switch_i;
        sync2_d  = sync1_q;
        hist_d   = hist_q;
        deb_d    = deb_q;
        fill_d   = fill_q;
        primed_d = primed_q;
        rdata_d  = rdata_q;
        set_mask = '0;
        clr_mask = '0;

        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

        // History as it will be after this tick's sample is shifted in
        for (int b = 0; b < NBITS; b++) begin
            hist_nxt[b] = {hist_q[b][STABLE_N-2:0], sync2_q[b]};
            agree1[b]   = &hist_nxt[b];
            agree0[b]   = ~|hist_nxt[b];
        end

        if (tick) begin
            hist_d = hist_nxt;
            if (!primed_q) begin
                // First full history seeds the debounced value without raising flags
                if (fill_q == FILL_LAST) begin
                    primed_d = 1'b1;
                    deb_d    = agree1;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end else begin
                set_mask = (agree1 & ~deb_q) | (agree0 & deb_q);
                deb_d    = deb_q ^ set_mask;
            end
        end

        rd_en = switchcs & switchread;
        if (rd_en) begin
            case (switchaddr)
                2'd0: rdata_d = deb_q[15:0];
                2'd1: rdata_d = {8'h00, deb_q[23:16]};
                2'd2: begin
                    rdata_d        = flag_q[15:0];
                    clr_mask[15:0] = '1;
                end
                2'd3: begin
                    rdata_d         = {8'h00, flag_q[23:16]};
                    clr_mask[23:16] = '1;
                end
            endcase
        end

        // A change landing on the clearing read survives it
        flag_d = (flag_q & ~clr_mask) | set_mask;
    end

    always_ff @(negedge switch_clk or posedge ledrst) begin
        if (ledrst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            hist_q   <= '0;
            deb_q    <= '0;
            flag_q   <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            deb_q    <= deb_d;
            flag_q   <= flag_d;
            fill_q   <= fill_d;
            primed_q <= primed_d;
            rdata_q  <= rdata_d;
        end
    end

    assign switchrdata = rdata_q;

endmodule

// File: tb/tb_switch_reader.sv
// Scoreboard bench for switch_reader: a tick-level reference model predicts read
// data, a monitor compares the held read port every cycle, plus directed checks.
module tb_switch_reader;

    localparam int unsigned TD = 4;
    localparam int unsigned SN = 3;

    logic        clk = 1'b1;
    logic        ledrst;
    logic        switchcs;
    logic        switchread;
    logic [1:0]  switchaddr;
    logic [23:0] switch_i;
    logic [15:0] switchrdata;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [23:0] m_raw[$];
    logic [23:0] m_samp[$];
    logic [23:0] m_deb;
    logic [23:0] m_flag;
    bit          m_primed;
    int          m_edge;

    switch_reader #(.TICK_DIV(TD), .STABLE_N(SN)) dut (
        .switch_clk (clk),
        .ledrst     (ledrst),
        .switchcs   (switchcs),
        .switchread (switchread),
        .switchaddr (switchaddr),
        .switch_i   (switch_i),
        .switchrdata(switchrdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: every TD-th edge takes a sample of the input seen two edges earlier;
    // the last SN samples decide acceptance, the first full set primes silently.
    task automatic model_proc();
        logic [23:0] s, a1, a0, set, clr;
        forever begin
            @(negedge clk or posedge ledrst);
            if (ledrst) begin
                m_raw.delete();
                m_samp.delete();
                m_deb    = '0;
                m_flag   = '0;
                m_primed = 1'b0;
                m_edge   = 0;
                exp_q.delete();
                exp_q.push_back(16'h0000);
            end else begin
                set = '0;
                clr = '0;
                if (switchcs && switchread) begin
                    case (switchaddr)
                        2'd0: exp_q.push_back(m_deb[15:0]);
                        2'd1: exp_q.push_back({8'h00, m_deb[23:16]});
                        2'd2: begin exp_q.push_back(m_flag[15:0]); clr = 24'h00FFFF; end
                        default: begin exp_q.push_back({8'h00, m_flag[23:16]}); clr = 24'hFF0000; end
                    endcase
                end
                if (m_edge % TD == TD - 1) begin
                    s = (m_raw.size() >= 2) ? m_raw[m_raw.size() - 2] : 24'h0;
                    m_samp.push_back(s);
                    if (m_samp.size() > SN) void'(m_samp.pop_front());
                    if (m_samp.size() == SN) begin
                        a1 = '1;
                        a0 = '1;
                        foreach (m_samp[i]) begin
                            a1 &= m_samp[i];
                            a0 &= ~m_samp[i];
                        end
                        if (!m_primed) begin
                            m_deb    = a1;
                            m_primed = 1'b1;
                        end else begin
                            set   = (a1 & ~m_deb) | (a0 & m_deb);
                            m_deb = m_deb ^ set;
                        end
                    end
                end
                m_flag = (m_flag & ~clr) | set;
                m_raw.push_back(switch_i);
                if (m_raw.size() > 2) void'(m_raw.pop_front());
                m_edge++;
            end
        end
    endtask

    task automatic monitor_proc();
        logic [15:0] hold = 16'h0000;
        forever begin
            @(posedge clk);
            while (exp_q.size() > 0) hold = exp_q.pop_front();
            check("rdata_scoreboard", switchrdata, hold);
        end
    endtask

    task automatic do_read(input logic [1:0] a, output logic [15:0] d);
        switchcs   = 1'b1;
        switchread = 1'b1;
        switchaddr = a;
        @(posedge clk);
        switchcs   = 1'b0;
        switchread = 1'b0;
        d = switchrdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [15:0] d;
        int j, k, acc;
        ledrst     = 1'b1;
        switchcs   = 1'b0;
        switchread = 1'b0;
        switchaddr = 2'd0;
        switch_i   = 24'hA5A5A5;
        fork
            model_proc();
            monitor_proc();
        join_none

        idle(3);
        check("reset_rdata", switchrdata, 16'h0000);
        ledrst = 1'b0;
        idle(14);
        do_read(2'd0, d); check("prime_addr0", d, 16'hA5A5);
        do_read(2'd1, d); check("prime_addr1", d, 16'h00A5);
        do_read(2'd2, d); check("prime_no_flags", d, 16'h0000);

        // Chip select low: strobe ignored, data holds
        switchread = 1'b1; switchaddr = 2'd2;
        idle(1);
        switchread = 1'b0;
        check("cs_low_hold", switchrdata, 16'h0000);

        switch_i[3] = 1'b1;
        idle(16);
        do_read(2'd0, d); check("bit3_deb", d, 16'hA5AD);
        do_read(2'd2, d); check("bit3_flag", d, 16'h0008);
        do_read(2'd2, d); check("bit3_cleared", d, 16'h0000);

        switch_i[20] = 1'b1;
        idle(5);
        switch_i[20] = 1'b0;
        idle(16);
        do_read(2'd1, d); check("glitch_addr1", d, 16'h00A5);
        do_read(2'd3, d); check("glitch_addr3", d, 16'h0000);

        switch_i[7] = 1'b0;
        idle(8);
        switch_i[7] = 1'b1;
        idle(16);
        do_read(2'd2, d); check("toggle_back_noflag", d, 16'h0000);

        // Set-wins: land the bit-0 re-acceptance exactly on an addr2 read
        switch_i[0] = 1'b0;
        idle(16);
        @(posedge clk);
        switch_i[0] = 1'b1;
        j = m_edge;
        k = j + 2;
        while (k % TD != TD - 1) k++;
        acc = k + (SN - 1) * TD;
        while (m_edge < acc) @(posedge clk);
        do_read(2'd2, d); check("setwins_old", d, 16'h0001);
        do_read(2'd2, d); check("setwins_kept", d, 16'h0001);
        do_read(2'd2, d); check("setwins_cleared", d, 16'h0000);

        switch_i[9] = 1'b1;
        idle(16);
        switch_i[9] = 1'b0;
        idle(16);
        do_read(2'd2, d); check("two_toggles", d, 16'h0200);
        do_read(2'd2, d); check("two_toggles_clr", d, 16'h0000);

        switch_i[23:16] = 8'h00;
        idle(16);
        do_read(2'd3, d); check("hi_to_zero", d, 16'h00A5);
        switch_i[23:16] = 8'hFF;
        switch_i[1]     = 1'b1;
        idle(16);
        do_read(2'd3, d); check("hi_ff", d, 16'h00FF);
        do_read(2'd3, d); check("hi_cleared", d, 16'h0000);
        do_read(2'd2, d); check("lo_untouched", d, 16'h0002);

        // Reset in the middle of bit 5 debouncing
        switch_i[5] = 1'b0;
        idle(6);
        #2 ledrst = 1'b1;
        #1 check("async_reset", switchrdata, 16'h0000);
        @(posedge clk);
        ledrst = 1'b0;
        idle(3);
        do_read(2'd0, d); check("unprimed_read", d, 16'h0000);
        idle(14);
        do_read(2'd2, d); check("reprime_noflag", d, 16'h0000);
        do_read(2'd0, d); check("reprime_addr0", d, 16'hA58F);
        do_read(2'd1, d); check("reprime_addr1", d, 16'h00FF);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 4))
                0: switch_i = switch_i ^ (24'h1 << $urandom_range(0, 23));
                1: switch_i = switch_i ^ 24'($urandom);
                2: begin
                    do_read(2'($urandom_range(0, 3)), d);
                end
                3: begin
                    switchread = 1'b1;
                    switchaddr = 2'($urandom_range(0, 3));
                    idle(1);
                    switchread = 1'b0;
                end
                default: idle($urandom_range(1, 14));
            endcase
            if (it == 120) begin
                #2 ledrst = 1'b1;
                @(posedge clk);
                ledrst = 1'b0;
            end
            idle(1);
        end
        for (int a = 0; a < 4; a++) do_read(2'(a), d);

        idle(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
